axi4lite_sram_slave: RTL and testbench
======================================

Name: axi4lite_sram_slave

Overview:
Synthesizable AXI4-Lite slave backed by a byte-addressed on-chip memory array. It sits directly downstream of the AXI4-Lite master BFM as the DUT that the BFM drives. It gives bus transactions a real RTL target with byte strobes, decode errors and independent read/write paths. Data width is N bytes (4 or 8).

Parameters:
N, 4, data bus width in bytes; legal values 4 or 8
SLAVE_ADDRESS, 32'h0000_0000, base address of the window
MEM_SIZE, 4096, window size in bytes; power of two, multiple of N

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  32  write address
AWPROT  in  3  write protection
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  8*N  write data
WSTRB  in  N  byte strobes
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  32  read address
ARPROT  in  3  read protection
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  8*N  read data
RRESP  out  2  read response

Behaviour:
- Reset (ARESETn low, asynchronous): AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=OKAY; RDATA=0. Holding registers cleared. Memory contents are not reset. All READYs rise on the first ACLK edge after deassertion.
- A reset mid-transaction drops the transaction; no partial write occurs after reset asserts.
- Address decode: offset = addr - SLAVE_ADDRESS (32-bit unsigned, wraps), then aligned down to N bytes.
  - offset >= MEM_SIZE gives DECERR. This includes addresses below the base, which wrap to large values.
  - In range gives OKAY.
- Write path: independent one-entry AW and W holding registers.
  - AWREADY = !aw_held; WREADY = !w_held. AW and W may arrive in any order or in the same cycle.
  - Write FSM states are W_IDLE and W_RESP.
  - In W_IDLE with both held: commit the write, set BVALID=1 and BRESP on the next edge, clear both holds, go to W_RESP.
  - Commit: for each lane i with WSTRB[i]=1, Mem[offset+i] = WDATA[8i+7:8i]. DECERR writes nothing.
  - In W_RESP: BVALID and BRESP are stable until BREADY. On BVALID&BREADY go to W_IDLE.
  - New AW/W may be accepted into the holds while in W_RESP; they commit after the response handshake.
- Read path: R FSM states are R_IDLE, R_DATA and R_RESP.
  - ARREADY=1 only in R_IDLE. On ARVALID&ARREADY, latch the address and go to R_DATA.
  - R_DATA: array read, one cycle. Next edge sets RVALID=1 with RDATA/RRESP and goes to R_RESP. Latency from AR handshake to RVALID is 2 cycles.
  - DECERR reads return RDATA=0.
  - In R_RESP: RVALID, RDATA and RRESP are stable until RREADY. On handshake go to R_IDLE; ARREADY reasserts the following cycle.
- Simultaneous write commit and array read to the same word: the read returns the pre-write data (read-first).
- Read and write paths are fully independent; neither stalls the other.
- AxPROT is ignored unless the optional feature is enabled.
- N=4: WDATA, RDATA and WSTRB are 32/4 bits wide.

Optional Feature:
AXI4LITE_SRAM_PROT_CHECK_EN
- Defined: a write with AWPROT[0]=0 (unprivileged) to an in-range address returns SLVERR with no memory update. A read with ARPROT[0]=0 returns SLVERR with RDATA=0. DECERR takes precedence over SLVERR.
- Undefined: PROT is ignored; responses are only OKAY or DECERR.

Decomposition:
- Package axi4lite_pkg: resp_t (2-bit), constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; enums for the write and read FSM states.
- Sub-module axi4lite_sram_bank: MEM_SIZE/N words x N byte lanes, one write port with per-byte enables and one registered read port, read-first.

Test Plan:
- Write 0xDEADBEEF to 0x10, WSTRB=4'hF, then read 0x10 -> BRESP=OKAY, RDATA=0xDEADBEEF, RRESP=OKAY, RVALID 2 cycles after AR handshake.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- W presented 3 cycles before AW, and the next case AW before W, both to 0x30 -> one commit each, BVALID only after both handshakes, data correct.
- Read 0x1000 (MEM_SIZE=4096) and write 0xFFFF_FFFC with SLAVE_ADDRESS=0 -> RRESP=DECERR, RDATA=0, BRESP=DECERR, no memory change (verify 0x0 unchanged).
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and payloads stable; a second AW+W is accepted into the holds but BVALID does not reassert until the first handshake.
- Assert ARESETn low while RVALID=1 and a write is half-held -> all outputs return to reset values asynchronously; after release, a read of the half-written address shows the old data.
- With AXI4LITE_SRAM_PROT_CHECK_EN defined: write with AWPROT=3'b000 -> SLVERR, memory unchanged; write with AWPROT=3'b001 -> OKAY.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the SRAM slave.
package axi4lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_RESP} r_state_t;

endpackage

// File: rtl/axi4lite_sram_bank.sv
// Byte-laned SRAM: one write port with per-byte enables, one registered read port (read-first).
module axi4lite_sram_bank #(
    parameter int N     = 4,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           i_clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [N-1:0]   i_wstrb,
    input  logic [8*N-1:0] i_wdata,
    input  logic           i_re,
    input  logic [AW-1:0]  i_raddr,
    output logic [8*N-1:0] o_rdata
);

    logic [N-1:0][7:0] r_mem [DEPTH];
    logic [8*N-1:0]    r_rdata;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N; i++) begin
            if (i_we && i_wstrb[i]) r_mem[i_waddr][i] <= i_wdata[8*i +: 8];
        end
        // Both updates land on the same edge, so a colliding read sees the old word.
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave over a byte-addressed SRAM window; independent read and write paths.
// Optional: define AXI4LITE_SRAM_PROT_CHECK_EN to reject unprivileged accesses with SLVERR.
module axi4lite_sram_slave
    import axi4lite_pkg::*;
#(
    parameter int          N             = 4,
    parameter logic [31:0] SLAVE_ADDRESS = 32'h0000_0000,
    parameter int          MEM_SIZE      = 4096
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic           AWVALID,
    output logic           AWREADY,
    input  logic [31:0]    AWADDR,
    input  logic [2:0]     AWPROT,
    input  logic           WVALID,
    output logic           WREADY,
    input  logic [8*N-1:0] WDATA,
    input  logic [N-1:0]   WSTRB,
    output logic           BVALID,
    input  logic           BREADY,
    output logic [1:0]     BRESP,
    input  logic           ARVALID,
    output logic           ARREADY,
    input  logic [31:0]    ARADDR,
    input  logic [2:0]     ARPROT,
    output logic           RVALID,
    input  logic           RREADY,
    output logic [8*N-1:0] RDATA,
    output logic [1:0]     RRESP
);

    localparam int LB    = $clog2(N);
    localparam int DEPTH = MEM_SIZE / N;
    localparam int AW    = $clog2(DEPTH);

    logic [31:0] w_aw_off, w_ar_off;
    resp_t       w_aw_resp, w_ar_resp;
    logic        w_unused;

    assign w_aw_off = AWADDR - SLAVE_ADDRESS;
    assign w_ar_off = ARADDR - SLAVE_ADDRESS;
    assign w_unused = ^{AWPROT, ARPROT};

    // Addresses below the base wrap to huge offsets and fall out of range here.
    always_comb begin
        w_aw_resp = RESP_OKAY;
        w_ar_resp = RESP_OKAY;
        if (w_aw_off >= 32'(MEM_SIZE)) w_aw_resp = RESP_DECERR;
`ifdef AXI4LITE_SRAM_PROT_CHECK_EN
        else if (!AWPROT[0])           w_aw_resp = RESP_SLVERR;
`endif
        if (w_ar_off >= 32'(MEM_SIZE)) w_ar_resp = RESP_DECERR;
`ifdef AXI4LITE_SRAM_PROT_CHECK_EN
        else if (!ARPROT[0])           w_ar_resp = RESP_SLVERR;
`endif
    end

    // READYs stay low through reset and come up on the first edge after release.
    logic r_rdy;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_rdy <= 1'b0;
        else          r_rdy <= 1'b1;
    end

    // ---------------- write path ----------------
    logic           r_aw_held, r_w_held;
    logic [AW-1:0]  r_aw_idx;
    resp_t          r_aw_resp, r_bresp;
    logic [8*N-1:0] r_wdata;
    logic [N-1:0]   r_wstrb;
    w_state_t       r_wstate, w_wstate_nxt;
    logic           w_commit, w_we;

    assign AWREADY = r_rdy & ~r_aw_held;
    assign WREADY  = r_rdy & ~r_w_held;
    assign BVALID  = (r_wstate == W_RESP);
    assign BRESP   = r_bresp;
    assign w_we    = w_commit && (r_aw_resp == RESP_OKAY);

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: if (r_aw_held && r_w_held) begin
                w_commit     = 1'b1;
                w_wstate_nxt = W_RESP;
            end
            W_RESP: if (BREADY) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_bresp   <= RESP_OKAY;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_resp <= RESP_OKAY;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_commit) r_bresp <= r_aw_resp;
            if (AWVALID && AWREADY) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_aw_off[LB +: AW];
                r_aw_resp <= w_aw_resp;
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (WVALID && WREADY) begin
                r_w_held <= 1'b1;
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t       r_rstate, w_rstate_nxt;
    logic [AW-1:0]  r_ar_idx;
    resp_t          r_ar_resp, r_rresp;
    logic           w_re;
    logic [8*N-1:0] w_bank_q;

    assign ARREADY = r_rdy & (r_rstate == R_IDLE);
    assign RVALID  = (r_rstate == R_RESP);
    assign RRESP   = r_rresp;
    // Error responses and idle cycles present zero data regardless of the bank register.
    assign RDATA   = (RVALID && r_rresp == RESP_OKAY) ? w_bank_q : '0;

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_re         = 1'b0;
        case (r_rstate)
            R_IDLE: if (ARVALID && ARREADY) w_rstate_nxt = R_DATA;
            R_DATA: begin
                w_re         = (r_ar_resp == RESP_OKAY);
                w_rstate_nxt = R_RESP;
            end
            R_RESP: if (RREADY) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_ar_idx  <= '0;
            r_ar_resp <= RESP_OKAY;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (ARVALID && ARREADY) begin
                r_ar_idx  <= w_ar_off[LB +: AW];
                r_ar_resp <= w_ar_resp;
            end
            if (r_rstate == R_DATA) r_rresp <= r_ar_resp;
        end
    end

    axi4lite_sram_bank #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_bank (
        .i_clk   (ACLK),
        .i_we    (w_we),
        .i_waddr (r_aw_idx),
        .i_wstrb (r_wstrb),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_raddr (r_ar_idx),
        .o_rdata (w_bank_q)
    );

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Scoreboard bench for axi4lite_sram_slave (N=4, base 0, 4 KiB window).
module tb_axi4lite_sram_slave;
    import axi4lite_pkg::*;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0;
    localparam int          MSZ  = 4096;

    logic        ACLK = 0, ARESETn = 0;
    logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [31:0] AWADDR = 0, ARADDR = 0, WDATA = 0, RDATA;
    logic [2:0]  AWPROT = 0, ARPROT = 0;
    logic [3:0]  WSTRB = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;

    axi4lite_sram_slave #(.N(N), .SLAVE_ADDRESS(BASE), .MEM_SIZE(MSZ)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0, n_fail = 0;
    logic [7:0]  mdl [MSZ];
    logic [1:0]  qb[$];
    logic [1:0]  qr_resp[$];
    logic [31:0] qr_data[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] mdl_resp(input logic [31:0] a, input logic [2:0] p);
        logic [31:0] off = a - BASE;
        if (off >= 32'(MSZ)) return RESP_DECERR;
`ifdef AXI4LITE_SRAM_PROT_CHECK_EN
        if (!p[0]) return RESP_SLVERR;
`endif
        if (p[2]) return RESP_OKAY;
        return RESP_OKAY;
    endfunction

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [2:0] p, output logic [1:0] r);
        int off;
        r = mdl_resp(a, p);
        off = int'((a - BASE) & ~32'h3);
        if (r == RESP_OKAY)
            for (int i = 0; i < N; i++) if (s[i]) mdl[off+i] = d[8*i +: 8];
        qb.push_back(r);
    endtask

    task automatic exp_read(input logic [31:0] a, input logic [2:0] p,
                            output logic [1:0] r, output logic [31:0] d);
        int off;
        r = mdl_resp(a, p);
        d = '0;
        off = int'((a - BASE) & ~32'h3);
        if (r == RESP_OKAY)
            for (int i = 0; i < N; i++) d[8*i +: 8] = mdl[off+i];
        qr_resp.push_back(r);
        qr_data.push_back(d);
    endtask

    // Response monitor: pop the scoreboard on every completed B/R handshake.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            if (qb.size() == 0) chk("b_unexpected", qb.size(), 1);
            else chk("bresp", BRESP, qb.pop_front());
        end
        if (ARESETn && RVALID && RREADY) begin
            if (qr_resp.size() == 0) chk("r_unexpected", qr_resp.size(), 1);
            else begin
                chk("rresp", RRESP, qr_resp.pop_front());
                chk("rdata", RDATA, qr_data.pop_front());
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
        int n = 0;
        AWADDR = a; AWPROT = p; AWVALID = 1;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
        chk("aw_accept", AWREADY, 1);
        @(posedge ACLK); #1; AWVALID = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d; WSTRB = s; WVALID = 1;
        do begin @(negedge ACLK); n++; end while (!WREADY && n < 50);
        chk("w_accept", WREADY, 1);
        @(posedge ACLK); #1; WVALID = 0;
    endtask

    task automatic wait_b(input int stall, input logic [1:0] er);
        int n = 0;
        BREADY = (stall == 0);
        do begin @(negedge ACLK); n++; end while (!BVALID && n < 50);
        chk("b_seen", BVALID, 1);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge ACLK);
                chk("b_hold_valid", BVALID, 1);
                chk("b_hold_resp", BRESP, er);
            end
            @(posedge ACLK); #1; BREADY = 1;
            @(negedge ACLK);
        end
        @(posedge ACLK); #1; BREADY = 0;
    endtask

    // order: 0 = AW and W together, 1 = W three cycles ahead, 2 = AW three cycles ahead
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, input int order, input int stall);
        logic [1:0] er;
        exp_write(a, d, s, p, er);
        if (order == 0) begin
            fork send_aw(a, p); send_w(d, s); join
        end else begin
            if (order == 1) send_w(d, s); else send_aw(a, p);
            repeat (3) begin @(negedge ACLK); chk("b_early", BVALID, 0); end
            @(posedge ACLK); #1;
            if (order == 1) send_aw(a, p); else send_w(d, s);
        end
        wait_b(stall, er);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int stall);
        logic [1:0]  er;
        logic [31:0] ed;
        int n = 0, lat = 0;
        exp_read(a, p, er, ed);
        RREADY = (stall == 0);
        ARADDR = a; ARPROT = p; ARVALID = 1;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
        chk("ar_accept", ARREADY, 1);
        @(posedge ACLK); #1; ARVALID = 0;
        do begin @(negedge ACLK); lat++; end while (!RVALID && lat < 50);
        chk("r_latency", lat, 2);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge ACLK);
                chk("r_hold_valid", RVALID, 1);
                chk("r_hold_data", RDATA, ed);
                chk("r_hold_resp", RRESP, er);
            end
            @(posedge ACLK); #1; RREADY = 1;
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("ar_reready", ARREADY, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, AWREADY, 0);
        chk({tag, "_wready"},  WREADY, 0);
        chk({tag, "_arready"}, ARREADY, 0);
        chk({tag, "_bvalid"},  BVALID, 0);
        chk({tag, "_rvalid"},  RVALID, 0);
        chk({tag, "_bresp"},   BRESP, RESP_OKAY);
        chk({tag, "_rresp"},   RRESP, RESP_OKAY);
        chk({tag, "_rdata"},   RDATA, 0);
    endtask

    initial begin
        logic [1:0] er;
        int n;
        #2 chk_reset_outputs("rst0");
        #20 ARESETn = 1;
        #1 chk("rdy_pre_edge", AWREADY, 0);
        @(negedge ACLK);
        chk("rdy_aw", AWREADY, 1); chk("rdy_w", WREADY, 1); chk("rdy_ar", ARREADY, 1);
        @(posedge ACLK); #1;

        do_write(32'h0,   32'hCAFEF00D, 4'hF, 3'b001, 0, 0);
        do_write(32'hFFC, 32'h0BADC0DE, 4'hF, 3'b001, 0, 0);
        do_write(32'h10,  32'hDEADBEEF, 4'hF, 3'b001, 0, 0);
        do_read (32'h10, 3'b001, 0);

        do_write(32'h20, 32'h11223344, 4'hF,    3'b001, 0, 0);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, 3'b001, 0, 0);
        do_read (32'h20, 3'b001, 0);
        chk("strb_merge", {mdl[35], mdl[34], mdl[33], mdl[32]}, 32'h11BB33DD);

        do_write(32'h30, 32'h30303030, 4'hF,    3'b001, 1, 0);
        do_read (32'h30, 3'b001, 0);
        do_write(32'h30, 32'h5A5A0000, 4'b1100, 3'b001, 2, 0);
        do_read (32'h30, 3'b001, 0);

        do_read (32'h1000,     3'b001, 0);
        do_write(32'hFFFFFFFC, 32'h12345678, 4'hF, 3'b001, 0, 0);
        do_read (32'h0,   3'b001, 0);
        do_read (32'hFFC, 3'b001, 0);

        // First response held off while a second write fills the holds.
        exp_write(32'h50, 32'h50505050, 4'hF, 3'b001, er);
        fork send_aw(32'h50, 3'b001); send_w(32'h50505050, 4'hF); join
        BREADY = 0; n = 0;
        do begin @(negedge ACLK); n++; end while (!BVALID && n < 50);
        chk("b1_seen", BVALID, 1);
        @(posedge ACLK); #1;
        exp_write(32'h54, 32'h54545454, 4'hF, 3'b001, er);
        fork send_aw(32'h54, 3'b001); send_w(32'h54545454, 4'hF); join
        repeat (5) begin
            @(negedge ACLK);
            chk("b1_stall_valid", BVALID, 1);
            chk("b1_stall_resp", BRESP, RESP_OKAY);
        end
        @(posedge ACLK); #1; BREADY = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        @(negedge ACLK); chk("b_gap", BVALID, 0);
        @(negedge ACLK); chk("b2_valid", BVALID, 1);
        @(posedge ACLK); #1; BREADY = 0;
        do_read(32'h50, 3'b001, 5);
        do_read(32'h54, 3'b001, 0);

        // Reset with a read response pending and only write data held.
        do_write(32'h40, 32'h01020304, 4'hF, 3'b001, 0, 0);
        RREADY = 0; ARADDR = 32'h10; ARPROT = 3'b001; ARVALID = 1;
        @(negedge ACLK);
        @(posedge ACLK); #1; ARVALID = 0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!RVALID && n < 50);
        chk("rst_rvalid_pre", RVALID, 1);
        @(posedge ACLK); #1;
        AWADDR = 32'h40;
        send_w(32'hFFFFFFFF, 4'hF);
        #2 ARESETn = 0;
        #1 chk_reset_outputs("rst1");
        @(negedge ACLK); @(negedge ACLK);
        #2 ARESETn = 1;
        @(negedge ACLK);
        chk("rst1_rdy", AWREADY & WREADY & ARREADY, 1);
        @(posedge ACLK); #1;
        do_read(32'h40, 3'b001, 0);

        do_write(32'h60, 32'h60606060, 4'hF, 3'b001, 0, 0);
        do_write(32'h60, 32'h99999999, 4'hF, 3'b000, 0, 0);
        do_read (32'h60, 3'b001, 0);
        do_read (32'h60, 3'b000, 0);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023)) * 4;
            do_write(a, $urandom, 4'hF, 3'b001, k % 3, 0);
            do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'b001, 0, 0);
            do_read (a, 3'b001, 0);
        end

        repeat (4) @(negedge ACLK);
        chk("qb_empty", qb.size(), 0);
        chk("qr_empty", qr_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
